keypad_scan_enc: RTL and testbench
==================================

// Module: keypad_scan_enc
// PURPOSE
//  4x4 matrix-keypad scanner/encoder; producer side of the keypad code stream (code + 1-cycle valid).
//  Drives keypad columns one at a time, samples rows, debounces press and release.
//  Emits exactly one o_code/o_code_vld per physical keypress; feeds code-lock FSMs directly.
// PARAMETERS
//  SCAN_DIV  1000  clock cycles each column is driven (dwell); rows sampled on last dwell cycle; >=4
//  DEBOUNCE  20    consecutive identical row samples required to accept a press or a release; >=1
// PORTS
//  i_clk       in   1  clock
//  i_rst       in   1  reset
//  i_row       in   4  keypad rows, active-low, asynchronous (pulled up when idle)
//  o_col       out  4  keypad column drive, active-low, exactly one bit low at all times
//  o_code      out  4  code of last accepted key; held until next accepted key
//  o_code_vld  out  1  1-cycle strobe, o_code valid in same cycle
//  o_key_down  out  1  high while an accepted key is held (PRESSED/RELEASE states)
// BEHAVIOUR
//  Reset i_rst, synchronous, active-high; clock i_clk.
//  Reset values: o_col=4'b1110, o_code=0, o_code_vld=0, o_key_down=0; state SCAN, col_idx=0, counters 0.
//  i_row passes a 2-FF synchronizer (reset to 4'hF); all decisions use the synchronized value row_s.
//  Dwell counter 0..SCAN_DIV-1, free-running in all states; "sample point" = dwell==SCAN_DIV-1.
//  o_col = ~(4'b0001 << col_idx), registered; col_idx changes only at a sample point in SCAN.
//  Key map (row,col): r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E(*) 0 F(#) D.
//  States:
//   SCAN: at sample point: row_s==4'hF -> col_idx<=col_idx+1 (3 wraps to 0).
//     else latch col_idx and lowest-index low row bit as key; match_cnt<=1; -> DEBOUNCE (col frozen).
//     If DEBOUNCE==1, go straight to PRESSED with strobe (below).
//   DEBOUNCE: at sample point: latched row bit low -> match_cnt+1; when count reaches DEBOUNCE
//     -> o_code<=key code, o_code_vld<=1 next cycle, -> PRESSED.
//     latched row bit high -> no strobe, col_idx+1, -> SCAN.
//   PRESSED: at sample point: latched row bit high -> rel_cnt<=1, -> RELEASE (or SCAN if DEBOUNCE==1).
//     Other rows/keys ignored (no rollover); no auto-repeat ever.
//   RELEASE: at sample point: row bit high -> rel_cnt+1; reaching DEBOUNCE -> col_idx+1, -> SCAN.
//     row bit low again -> PRESSED, rel_cnt cleared, no new strobe.
//  o_key_down = (state==PRESSED || state==RELEASE), registered.
//  Latency: vld asserts 1 cycle after the DEBOUNCE-th matching sample; +2 cycles synchronizer
//   from pin to row_s.
//  Multiple keys: first column hit in scan order wins; within a column, lowest row index wins.
//  Reset mid-operation: any state returns to SCAN/col 0; pending press discarded, no strobe.
//  Counter widths: $clog2(SCAN_DIV), $clog2(DEBOUNCE+1); counters saturate, never wrap.
// TESTING  (SCAN_DIV=4, DEBOUNCE=3; keypad model ties row r low when col c low and key(r,c) closed)
//  1 Reset, no keys -> outputs at reset values; o_col cycles 1110,1101,1011,0111,1110 every 4 clk.
//  2 Hold '5'(r1,c1) 200 clk -> single o_code_vld, o_code=5; o_col stays 1101; o_key_down=1; no repeat.
//  3 Press '0'(r3,c1) for 1 sample only -> no vld; scanning resumes with o_col=1011.
//  4 Hold '#', release 1 sample, press again, then release 3+ samples
//    -> exactly one vld, code 4'hF; o_key_down drops after release accepted.
//  5 '1' and '2' held together from reset -> one vld, code 1; '2' accepted only after '1' released.
//  6 Assert i_rst during DEBOUNCE of '7' -> no vld; o_col=1110, state SCAN; re-press '7' -> code 7.

Source files
------------

// File: rtl/keypad_scan_enc_if.sv
// Keypad pins plus the key-code stream toward the code-lock consumer.
// The scanner uses the master side; the keypad/consumer side uses slave.
interface keypad_scan_enc_if;
  logic [3:0] i_row;
  logic [3:0] o_col;
  logic [3:0] o_code;
  logic       o_code_vld;
  logic       o_key_down;

  modport master (
    input  i_row,
    output o_col, o_code, o_code_vld, o_key_down
  );

  modport slave (
    output i_row,
    input  o_col, o_code, o_code_vld, o_key_down
  );
endinterface

// File: rtl/keypad_scan_enc.sv
// 4x4 matrix-keypad scanner with press/release debounce.
// Emits one code strobe per physical keypress.
//
// state    | meaning
// SCAN     | walking columns, looking for any low row
// DEBOUNCE | column frozen, counting matching press samples
// PRESSED  | key accepted and strobed, waiting for release
// RELEASE  | counting high samples before accepting the release
module keypad_scan_enc #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  keypad_scan_enc_if.master  kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    row_m_q, row_s_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    key_row_q, key_row_d;
  logic [CW-1:0] match_q, match_d;
  logic [CW-1:0] rel_q, rel_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    code_q, code_d;
  logic          vld_q, vld_d;
  logic          key_down_q, key_down_d;

  logic          sample;
  logic          key_low;
  logic [1:0]    low_row;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_code = 4'h1;
      4'b00_01: key_code = 4'h2;
      4'b00_10: key_code = 4'h3;
      4'b00_11: key_code = 4'hA;
      4'b01_00: key_code = 4'h4;
      4'b01_01: key_code = 4'h5;
      4'b01_10: key_code = 4'h6;
      4'b01_11: key_code = 4'hB;
      4'b10_00: key_code = 4'h7;
      4'b10_01: key_code = 4'h8;
      4'b10_10: key_code = 4'h9;
      4'b10_11: key_code = 4'hC;
      4'b11_00: key_code = 4'hE;
      4'b11_01: key_code = 4'h0;
      4'b11_10: key_code = 4'hF;
      default:  key_code = 4'hD;
    endcase
  endfunction

  assign sample  = (dwell_q == DWELL_LAST);
  assign key_low = ~row_s_q[key_row_q];

  always_comb begin
    if (!row_s_q[0])      low_row = 2'd0;
    else if (!row_s_q[1]) low_row = 2'd1;
    else if (!row_s_q[2]) low_row = 2'd2;
    else                  low_row = 2'd3;
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    key_row_d = key_row_q;
    match_d   = match_q;
    rel_d     = rel_q;
    code_d    = code_q;
    vld_d     = 1'b0;
    dwell_d   = sample ? '0 : dwell_q + DW'(1);

    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (row_s_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            key_row_d = low_row;
            if (DEBOUNCE == 1) begin
              code_d  = key_code(low_row, col_idx_q);
              vld_d   = 1'b1;
              state_d = ST_PRESSED;
            end else begin
              match_d = CW'(1);
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (key_low) begin
            if (match_q == CNT_LAST) begin
              code_d  = key_code(key_row_q, col_idx_q);
              vld_d   = 1'b1;
              state_d = ST_PRESSED;
            end
            match_d = (match_q == CNT_MAX) ? match_q : match_q + CW'(1);
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (!key_low) begin
            if (DEBOUNCE == 1) begin
              col_idx_d = col_idx_q + 2'd1;
              state_d   = ST_SCAN;
            end else begin
              rel_d   = CW'(1);
              state_d = ST_RELEASE;
            end
          end
        end
        default: begin
          if (!key_low) begin
            if (rel_q == CNT_LAST) begin
              col_idx_d = col_idx_q + 2'd1;
              state_d   = ST_SCAN;
            end
            rel_d = (rel_q == CNT_MAX) ? rel_q : rel_q + CW'(1);
          end else begin
            rel_d   = '0;
            state_d = ST_PRESSED;
          end
        end
      endcase
    end

    // Column drive and key_down track the next state so they change on the same edge.
    col_d      = ~(4'b0001 << col_idx_d);
    key_down_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_m_q    <= 4'hF;
      row_s_q    <= 4'hF;
      state_q    <= ST_SCAN;
      dwell_q    <= '0;
      col_idx_q  <= 2'd0;
      key_row_q  <= 2'd0;
      match_q    <= '0;
      rel_q      <= '0;
      col_q      <= 4'b1110;
      code_q     <= 4'h0;
      vld_q      <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      row_m_q    <= kp.i_row;
      row_s_q    <= row_m_q;
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      col_idx_q  <= col_idx_d;
      key_row_q  <= key_row_d;
      match_q    <= match_d;
      rel_q      <= rel_d;
      col_q      <= col_d;
      code_q     <= code_d;
      vld_q      <= vld_d;
      key_down_q <= key_down_d;
    end
  end

  assign kp.o_col      = col_q;
  assign kp.o_code     = code_q;
  assign kp.o_code_vld = vld_q;
  assign kp.o_key_down = key_down_q;

endmodule

// File: tb/tb_keypad_scan_enc.sv
// Bench for keypad_scan_enc: keypad switch model plus a code scoreboard.
module tb_keypad_scan_enc;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  keypad_scan_enc_if kif ();

  keypad_scan_enc #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .kp    (kif)
  );

  // keys[r][c] closed pulls row r low while column c is driven low
  logic       keys [4][4];
  logic [3:0] row_v;
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_v[r] = 1'b1;
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !kif.o_col[c]) row_v[r] = 1'b0;
    end
  end
  assign kif.i_row = row_v;

  int n_chk  = 0;
  int n_pass = 0;
  logic [3:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  always @(negedge i_clk) begin
    if (kif.o_code_vld === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_vld", kif.o_code_vld, 1'b0);
      else chk("code", kif.o_code, exp_q.pop_front());
    end
  end

  task automatic clear_keys();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) keys[r][c] = 1'b0;
  endtask

  task automatic wait_kd(input logic val, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (kif.o_key_down === val) break;
      @(negedge i_clk);
    end
    chk(tag, kif.o_key_down, val);
  endtask

  task automatic wait_col(input logic [3:0] val, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (kif.o_col === val) break;
      @(negedge i_clk);
    end
    chk(tag, kif.o_col, val);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_col;
    clear_keys();

    // 1: reset values and idle column walk
    repeat (3) @(negedge i_clk);
    chk("rst_col", kif.o_col, 4'b1110);
    chk("rst_code", kif.o_code, 4'h0);
    chk("rst_vld", kif.o_code_vld, 1'b0);
    chk("rst_kd", kif.o_key_down, 1'b0);
    i_rst = 1'b0;
    for (int n = 0; n <= 16; n++) begin
      if (n % 4 == 0 || n % 4 == 3) begin
        exp_col = ~(4'b0001 << ((n / 4) % 4));
        chk("col_walk", kif.o_col, exp_col);
      end
      @(negedge i_clk);
    end
    chk("idle_kd", kif.o_key_down, 1'b0);

    // 2: hold '5' long, exactly one strobe
    keys[1][1] = 1'b1;
    exp_q.push_back(4'h5);
    wait_kd(1'b1, 100, "k5_down");
    repeat (200) @(negedge i_clk);
    chk("k5_col", kif.o_col, 4'b1101);
    chk("k5_kd", kif.o_key_down, 1'b1);
    keys[1][1] = 1'b0;
    wait_kd(1'b0, 100, "k5_up");
    chk("k5_hold", kif.o_code, 4'h5);
    chk("k5_pend", exp_q.size(), 0);

    // 3: '0' seen for a single sample only
    wait_col(4'b1110, 40, "k0_pre");
    wait_col(4'b1101, 40, "k0_align");
    keys[3][1] = 1'b1;
    repeat (4) @(negedge i_clk);
    keys[3][1] = 1'b0;
    wait_col(4'b1011, 40, "k0_resume");
    chk("k0_kd", kif.o_key_down, 1'b0);
    repeat (8) @(negedge i_clk);
    chk("k0_code", kif.o_code, 4'h5);

    // 4: '#' with a one-sample release glitch
    keys[3][2] = 1'b1;
    exp_q.push_back(4'hF);
    wait_kd(1'b1, 100, "kf_down");
    repeat (12) @(negedge i_clk);
    keys[3][2] = 1'b0;
    repeat (4) @(negedge i_clk);
    keys[3][2] = 1'b1;
    repeat (16) @(negedge i_clk);
    chk("kf_glitch_kd", kif.o_key_down, 1'b1);
    keys[3][2] = 1'b0;
    wait_kd(1'b0, 100, "kf_up");
    chk("kf_rel_col", kif.o_col, 4'b0111);
    chk("kf_pend", exp_q.size(), 0);

    // 5: '1' and '2' together from reset
    i_rst = 1'b1;
    keys[0][0] = 1'b1;
    keys[0][1] = 1'b1;
    exp_q.push_back(4'h1);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    wait_kd(1'b1, 100, "k12_down");
    chk("k12_col", kif.o_col, 4'b1110);
    repeat (20) @(negedge i_clk);
    chk("k12_pend1", exp_q.size(), 0);
    keys[0][0] = 1'b0;
    exp_q.push_back(4'h2);
    wait_kd(1'b0, 100, "k1_up");
    wait_kd(1'b1, 100, "k2_down");
    chk("k2_col", kif.o_col, 4'b1101);
    keys[0][1] = 1'b0;
    wait_kd(1'b0, 100, "k2_up");
    chk("k2_pend", exp_q.size(), 0);

    // 6: reset during debounce of '7', then a clean press
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    keys[2][0] = 1'b1;
    i_rst = 1'b0;
    repeat (6) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("k7_rst_col", kif.o_col, 4'b1110);
    chk("k7_rst_kd", kif.o_key_down, 1'b0);
    chk("k7_rst_vld", kif.o_code_vld, 1'b0);
    chk("k7_rst_code", kif.o_code, 4'h0);
    exp_q.push_back(4'h7);
    i_rst = 1'b0;
    wait_kd(1'b1, 100, "k7_down");
    keys[2][0] = 1'b0;
    wait_kd(1'b0, 100, "k7_up");
    chk("k7_code", kif.o_code, 4'h7);
    repeat (20) @(negedge i_clk);
    chk("final_pend", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
